// File: rtl/omok_turn_sequencer_if.sv
// Board-side bus of the omok turn sequencer: player pulses in, board writes and game status out.
// The sequencer drives the slave modport; the cursor/button logic and board memory sit on the master side.
interface omok_turn_sequencer_if #(
  parameter int BOARD_DIM = 10
);
  localparam int CELLS = BOARD_DIM * BOARD_DIM;

  // put/undo are single-cycle pulses with no ready: they take effect only if
  // sampled while busy=0, otherwise they are dropped (never queued).
  logic                   put;
  logic                   undo;
  logic [7:0]             cur_pos;
  logic [2*CELLS-1:0]     board_state;
  logic                   wr_en;
  logic [7:0]             wr_pos;
  logic [1:0]             wr_val;
  logic                   clr_board;
  logic                   turn;
  logic                   busy;
  logic                   reject;
  logic                   game_over;
  logic [1:0]             winner;

  modport slave (
    input  put, undo, cur_pos, board_state,
    output wr_en, wr_pos, wr_val, clr_board, turn, busy, reject, game_over, winner
  );

  modport master (
    output put, undo, cur_pos, board_state,
    input  wr_en, wr_pos, wr_val, clr_board, turn, busy, reject, game_over, winner
  );
endinterface

// File: rtl/omok_turn_sequencer.sv
// Omok game-flow controller: places/undoes stones, scans for five-in-a-row over several
// cycles, and clears the board after a win or a full-board draw.
module omok_turn_sequencer #(
  parameter int BOARD_DIM  = 10,
  parameter int HIST_DEPTH = 16,
  parameter int OVER_HOLD  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  omok_turn_sequencer_if.slave  bus,
  output logic [2:0]            o_dbg_state
);
  localparam int CELLS = BOARD_DIM * BOARD_DIM;
  localparam int HW    = $clog2(HIST_DEPTH);
  localparam int MW    = $clog2(CELLS + 1);
  localparam int OW    = $clog2(OVER_HOLD + 1);
  localparam logic [7:0]        DIM8  = 8'(BOARD_DIM);
  localparam logic [7:0]        CELL8 = 8'(CELLS);
  localparam logic signed [9:0] DIMS  = 10'(BOARD_DIM);

  typedef enum logic [2:0] {
    S_IDLE, S_PLACE, S_CHECK, S_UNDO, S_OVER, S_CLEAR
  } state_t;

  state_t         r_state;
  logic           r_wr_en, r_clr, r_turn, r_busy, r_reject, r_go;
  logic [7:0]     r_wr_pos;
  logic [1:0]     r_wr_val, r_winner, r_color;
  logic [7:0]     r_hist [HIST_DEPTH];
  logic [HW-1:0]  r_hptr;
  logic [HW:0]    r_hcnt;
  logic [MW-1:0]  r_mcnt;
  logic [7:0]     r_row, r_col, r_pr, r_pc;
  logic [1:0]     r_dir;
  logic           r_back;
  logic [2:0]     r_cnt;
  logic [OW-1:0]  r_hold;

  logic signed [9:0] w_dr, w_dc, w_nr, w_nc;
  logic              w_inb, w_step_ok, w_in_range;
  logic [7:0]        w_nidx, w_cidx, w_crow, w_ccol;
  logic [1:0]        w_ncell, w_ccell;
  logic [HW-1:0]     w_hprev, w_hnext;

  // Probe step: bounds are tested on row/column before the cell index is formed,
  // so a step off the right edge never aliases onto the next row.
  always_comb begin
    w_dr = '0;
    w_dc = '0;
    case (r_dir)
      2'd0: w_dc = 10'sd1;
      2'd1: w_dr = 10'sd1;
      2'd2: begin w_dr = 10'sd1; w_dc = 10'sd1; end
      default: begin w_dr = 10'sd1; w_dc = -10'sd1; end
    endcase
    if (r_back) begin
      w_dr = -w_dr;
      w_dc = -w_dc;
    end
    w_nr      = $signed({2'b00, r_pr}) + w_dr;
    w_nc      = $signed({2'b00, r_pc}) + w_dc;
    w_inb     = (w_nr >= 0) && (w_nr < DIMS) && (w_nc >= 0) && (w_nc < DIMS);
    w_nidx    = w_inb ? 8'(w_nr[7:0] * DIM8 + w_nc[7:0]) : 8'd0;
    w_ncell   = bus.board_state[2*w_nidx +: 2];
    w_step_ok = w_inb && (w_ncell == r_color);

    w_in_range = bus.cur_pos < CELL8;
    w_cidx     = w_in_range ? bus.cur_pos : 8'd0;
    w_ccell    = bus.board_state[2*w_cidx +: 2];
    w_crow     = w_cidx / DIM8;
    w_ccol     = w_cidx % DIM8;

    w_hprev = (r_hptr == '0) ? HW'(HIST_DEPTH - 1) : r_hptr - 1'b1;
    w_hnext = (r_hptr == HW'(HIST_DEPTH - 1)) ? '0 : r_hptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wr_en  <= 1'b0;
      r_wr_pos <= '0;
      r_wr_val <= '0;
      r_clr    <= 1'b0;
      r_turn   <= 1'b0;
      r_busy   <= 1'b0;
      r_reject <= 1'b0;
      r_go     <= 1'b0;
      r_winner <= '0;
      r_color  <= '0;
      r_hptr   <= '0;
      r_hcnt   <= '0;
      r_mcnt   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_pr     <= '0;
      r_pc     <= '0;
      r_dir    <= '0;
      r_back   <= 1'b0;
      r_cnt    <= '0;
      r_hold   <= '0;
    end else begin
      r_wr_en  <= 1'b0;
      r_clr    <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.undo) begin
            if (r_hcnt != '0) begin
              r_wr_en  <= 1'b1;
              r_wr_pos <= r_hist[w_hprev];
              r_wr_val <= 2'b00;
              r_busy   <= 1'b1;
              r_state  <= S_UNDO;
            end
          end else if (bus.put) begin
            if (w_in_range && (w_ccell == 2'b00)) begin
              r_wr_en  <= 1'b1;
              r_wr_pos <= bus.cur_pos;
              r_wr_val <= r_turn ? 2'b10 : 2'b11;
              r_color  <= r_turn ? 2'b10 : 2'b11;
              r_row    <= w_crow;
              r_col    <= w_ccol;
              r_busy   <= 1'b1;
              r_state  <= S_PLACE;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        S_PLACE: begin
          r_hist[r_hptr] <= r_wr_pos;
          r_hptr <= w_hnext;
          if (r_hcnt != (HW+1)'(HIST_DEPTH)) r_hcnt <= r_hcnt + 1'b1;
          r_mcnt  <= r_mcnt + 1'b1;
          r_dir   <= 2'd0;
          r_back  <= 1'b0;
          r_cnt   <= 3'd1;
          r_pr    <= r_row;
          r_pc    <= r_col;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_step_ok) begin
            if (r_cnt == 3'd4) begin
              r_go     <= 1'b1;
              r_winner <= r_color;
              r_hold   <= '0;
              r_state  <= S_OVER;
            end else begin
              r_cnt <= r_cnt + 3'd1;
              r_pr  <= w_nr[7:0];
              r_pc  <= w_nc[7:0];
            end
          end else begin
            // Run ended: restart from the placed cell, backward half or next direction.
            r_pr <= r_row;
            r_pc <= r_col;
            if (!r_back) begin
              r_back <= 1'b1;
            end else if (r_dir != 2'd3) begin
              r_back <= 1'b0;
              r_dir  <= r_dir + 2'd1;
              r_cnt  <= 3'd1;
            end else if (r_mcnt == MW'(CELLS)) begin
              r_go     <= 1'b1;
              r_winner <= 2'b00;
              r_hold   <= '0;
              r_state  <= S_OVER;
            end else begin
              r_turn  <= ~r_turn;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_UNDO: begin
          r_hptr  <= w_hprev;
          r_hcnt  <= r_hcnt - 1'b1;
          r_mcnt  <= r_mcnt - 1'b1;
          r_turn  <= ~r_turn;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_OVER: begin
          if (r_hold == OW'(OVER_HOLD - 1)) begin
            r_go     <= 1'b0;
            r_winner <= 2'b00;
            r_clr    <= 1'b1;
            r_state  <= S_CLEAR;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_CLEAR: begin
          r_hptr  <= '0;
          r_hcnt  <= '0;
          r_mcnt  <= '0;
          r_turn  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.wr_pos    = r_wr_pos;
  assign bus.wr_val    = r_wr_val;
  assign bus.clr_board = r_clr;
  assign bus.turn      = r_turn;
  assign bus.busy      = r_busy;
  assign bus.reject    = r_reject;
  assign bus.game_over = r_go;
  assign bus.winner    = r_winner;
  assign o_dbg_state   = r_state;
endmodule
